// File: rtl/kd_poly_io.sv
// Host coefficient streaming port for the four-bank NTT memory: loads a polynomial from a
// valid/ready stream and unloads it back. Define KD_IO_BITREV_EN to bit-reverse stream indices.
module kd_poly_io #(
  parameter int unsigned N      = 256,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [3:0]        bank_wen,
  output logic [ADDR_W-1:0] bank_waddr,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              bank_ren,
  output logic [ADDR_W-1:0] bank_raddr,
  output logic [1:0]        bank_rsel,
  input  logic [DATA_W-1:0] bank_q0,
  input  logic [DATA_W-1:0] bank_q1,
  input  logic [DATA_W-1:0] bank_q2,
  input  logic [DATA_W-1:0] bank_q3
);

  localparam int unsigned LogN = $clog2(N);
  localparam int unsigned IdxW = LogN + 1;
  localparam logic [IdxW-1:0] NIdx    = IdxW'(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StUnload, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, idx_inc;
  logic [1:0]        fifo_count_q, fifo_count_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_q [3];
  logic              inflight_q;
  logic [1:0]        rsel_q;

  logic [8:0]        coef;
  logic [1:0]        cur_bank;
  logic [ADDR_W-1:0] cur_addr;
  logic              hs, ren, push, pop;
  logic [DATA_W-1:0] rd_data;

  // Stream index to coefficient index; bits above LogN stay zero.
  function automatic logic [8:0] coef_of(logic [IdxW-1:0] s);
    logic [8:0] c;
    c = '0;
    for (int unsigned i = 0; i < LogN; i++) begin
`ifdef KD_IO_BITREV_EN
      c[i] = s[LogN-1-i];
`else
      c[i] = s[i];
`endif
    end
    return c;
  endfunction

  // Digit-sum mapping shared with the butterfly datapath; 2-bit sum wraps mod 4.
  function automatic logic [1:0] bank_of(logic [8:0] c);
    return c[1:0] + c[3:2] + c[5:4] + c[7:6] + {1'b0, c[8]};
  endfunction

  assign coef     = coef_of(idx_q);
  assign cur_bank = bank_of(coef);
  assign cur_addr = ADDR_W'(coef >> 2);
  assign idx_inc  = (idx_q == NIdx) ? idx_q : idx_q + 1'b1;

  assign hs   = (state_q == StLoad) && s_valid;
  assign push = inflight_q;
  assign pop  = m_valid && m_ready;
  // Registered count plus in-flight read bounds occupancy so the FIFO cannot overflow.
  assign ren  = (state_q == StUnload) && (idx_q < NIdx) &&
                (({1'b0, fifo_count_q} + {2'b00, inflight_q}) < 3'd3);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = dir ? StUnload : StLoad;
        end
      end
      StLoad: begin
        if (hs) begin
          idx_d = idx_inc;
          if (idx_q == LastIdx) state_d = StDone;
        end
      end
      StUnload: begin
        if (ren) begin
          idx_d = idx_inc;
          if (idx_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as the last entry pops so done lands one cycle after it.
        if (!inflight_q && (fifo_count_q == 2'd0 || (fifo_count_q == 2'd1 && pop))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 2'd1;
      2'b01:   fifo_count_d = fifo_count_q - 2'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_comb begin
    rd_data = bank_q0;
    unique case (rsel_q)
      2'd0: rd_data = bank_q0;
      2'd1: rd_data = bank_q1;
      2'd2: rd_data = bank_q2;
      2'd3: rd_data = bank_q3;
      default: rd_data = bank_q0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      inflight_q   <= 1'b0;
      rsel_q       <= '0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      inflight_q   <= ren;
      if (ren)  rsel_q <= cur_bank;
      if (push) fifo_q[wr_ptr_q] <= rd_data;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign s_ready    = (state_q == StLoad);
  assign m_valid    = (fifo_count_q != 2'd0);
  assign m_data     = fifo_q[rd_ptr_q];
  assign bank_wen   = hs ? (4'b0001 << cur_bank) : 4'b0000;
  assign bank_waddr = hs ? cur_addr : '0;
  assign bank_wdata = hs ? s_data : '0;
  assign bank_ren   = ren;
  assign bank_raddr = ren ? cur_addr : '0;
  assign bank_rsel  = ren ? cur_bank : 2'd0;

endmodule

// File: tb/tb_kd_poly_io.sv
// Self-checking bench for kd_poly_io: bank RAM model, write log, output scoreboard.
module tb_kd_poly_io;
  localparam int N    = 256;
  localparam int LOGN = 8;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0;
  logic        s_valid = 1'b0, m_ready = 1'b0;
  logic [11:0] s_data = '0;
  logic        busy, done, s_ready, m_valid, bank_ren;
  logic [11:0] m_data, bank_wdata;
  logic [3:0]  bank_wen;
  logic [6:0]  bank_waddr, bank_raddr;
  logic [1:0]  bank_rsel;
  logic [11:0] q0, q1, q2, q3;
  logic [11:0] mem [4][128];

  int vec_cnt = 0, err_cnt = 0;
  int pop_cnt = 0, occ = 0, max_occ = 0, stray_wr = 0;
  int loaded [N];
  int exp_q [$];

  typedef struct packed {logic [3:0] wen; logic [6:0] addr; logic [11:0] data;} wr_t;
  wr_t wlog [$];

  typedef struct {int sidx; int bank; int addr;} wvec_t;
  wvec_t vecs [8];

  kd_poly_io dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
    .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rsel(bank_rsel),
    .bank_q0(q0), .bank_q1(q1), .bank_q2(q2), .bank_q3(q3)
  );

  always #5 clk = ~clk;

  // Bank RAMs: synchronous write, read data one cycle after bank_ren.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (bank_wen[b]) mem[b][bank_waddr] <= bank_wdata;
    if (bank_ren) begin
      case (bank_rsel)
        2'd0: q0 <= mem[0][bank_raddr];
        2'd1: q1 <= mem[1][bank_raddr];
        2'd2: q2 <= mem[2][bank_raddr];
        default: q3 <= mem[3][bank_raddr];
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {busy, done, s_ready, m_valid, bank_wen, bank_ren, bank_waddr, bank_wdata,
               bank_raddr, bank_rsel, m_data}, 64'd0);
  endtask

  function automatic int coef_of(int s);
`ifdef KD_IO_BITREV_EN
    int c = 0;
    for (int b = 0; b < LOGN; b++) if (s[b]) c |= 1 << (LOGN - 1 - b);
    return c;
`else
    return s;
`endif
  endfunction

  function automatic int bank_of(int c);
    return (c + (c >> 2) + (c >> 4) + (c >> 6) + (c >> 8)) & 3;
  endfunction

  // Monitor away from the active edge: write log, stray writes, pops, occupancy.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (s_valid && s_ready) wlog.push_back({bank_wen, bank_waddr, bank_wdata});
      else if (bank_wen != 4'd0) stray_wr++;
      if (bank_ren) begin
        occ++;
        if (occ > max_occ) max_occ = occ;
      end
      if (m_valid && m_ready) begin
        pop_cnt++;
        occ--;
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else chk("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_load(input bit gaps, input int mode, output int done_cyc);
    int sent = 0;
    int cyc;
    wlog.delete();
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 5000) begin
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_load_done", busy, 1);
        break;
      end
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      case (mode)
        0: s_data = 12'(sent);
        1: s_data = 12'(sent * 37 + 5);
        default: s_data = 12'(sent + 1000);
      endcase
      if (s_valid && s_ready && sent < N) begin
        loaded[sent] = int'(s_data);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_load", busy, 0);
    chk("load_writes", wlog.size(), N);
  endtask

  task automatic do_unload(input bit toggle, input int abort_at,
                           output int first_valid, output int last_pop, output int done_cyc);
    int cyc;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(loaded[i]);
    pop_cnt = 0; max_occ = 0;
    first_valid = -1; last_pop = -1; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 5000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      m_ready = toggle ? pat[cyc % 4] : 1'b1;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) last_pop = cyc;
      if (abort_at >= 0 && pop_cnt >= abort_at) begin
        #3 rst = 1'b0;
        #1 chk_reset("reset_mid_unload");
        @(negedge clk);
        rst = 1'b1;
        occ = 0;
        exp_q.delete();
        break;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
  endtask

  initial begin
    int dc, fv, lp;

`ifdef KD_IO_BITREV_EN
    vecs[0] = '{0, 0, 0};   vecs[1] = '{1, 2, 32};  vecs[2] = '{2, 1, 16};
    vecs[3] = '{3, 3, 48};  vecs[4] = '{4, 2, 8};   vecs[5] = '{5, 0, 40};
    vecs[6] = '{128, 1, 0}; vecs[7] = '{255, 0, 63};
`else
    vecs[0] = '{0, 0, 0};    vecs[1] = '{1, 1, 0};   vecs[2] = '{4, 1, 1};
    vecs[3] = '{5, 2, 1};    vecs[4] = '{17, 2, 4};  vecs[5] = '{100, 0, 25};
    vecs[6] = '{128, 2, 32}; vecs[7] = '{255, 0, 63};
`endif

    #1 rst = 1'b0;
    #11 chk_reset("reset_init");
    @(negedge clk);
    rst = 1'b1;

    // Continuous load of s_data = idx.
    do_load(1'b0, 0, dc);
    chk("load_done_cycle", dc, N + 1);
    for (int v = 0; v < 8; v++) begin
      chk($sformatf("wen_idx%0d", vecs[v].sidx), wlog[vecs[v].sidx].wen, 4'b0001 << vecs[v].bank);
      chk($sformatf("waddr_idx%0d", vecs[v].sidx), wlog[vecs[v].sidx].addr, vecs[v].addr);
      chk($sformatf("wdata_idx%0d", vecs[v].sidx), wlog[vecs[v].sidx].data, vecs[v].sidx);
    end

    // Unload with m_ready held high.
    do_unload(1'b0, -1, fv, lp, dc);
    chk("unload_first_valid", fv, 3);
    chk("unload_last_pop", lp, N + 2);
    chk("unload_done_cycle", dc, lp + 1);
    chk("unload_pops", pop_cnt, N);
    chk("unload_sb_left", exp_q.size(), 0);

    // Unload with m_ready toggling 1,0,0,1.
    do_unload(1'b1, -1, fv, lp, dc);
    chk("toggle_done_after_pop", dc, lp + 1);
    chk("toggle_pops", pop_cnt, N);
    chk("toggle_sb_left", exp_q.size(), 0);
    chk("toggle_max_occ", max_occ, 3);

    // Load with random s_valid gaps; check the bank image.
    stray_wr = 0;
    do_load(1'b1, 1, dc);
    chk("gap_load_finished", dc > 0, 1);
    chk("stray_writes", stray_wr, 0);
    for (int i = 0; i < N; i++) begin
      int c;
      c = coef_of(i);
      chk($sformatf("image_%0d", i), mem[bank_of(c)][c >> 2], loaded[i]);
    end

    // Abort an unload with reset after 100 pops.
    do_unload(1'b0, 100, fv, lp, dc);
    chk("abort_pops", pop_cnt >= 100, 1);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
    end
    chk("idle_after_abort", busy, 0);

    // Clean load and unload after the abort.
    do_load(1'b0, 2, dc);
    chk("reload_done_cycle", dc, N + 1);
    do_unload(1'b0, -1, fv, lp, dc);
    chk("reunload_first_valid", fv, 3);
    chk("reunload_done_cycle", dc, N + 3);
    chk("reunload_pops", pop_cnt, N);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
